// File: rtl/mux8_share_arbiter.sv
// Round-robin arbiter that shares one 8:1 mux among eight requesters.
// Select lines, grant and VALID all come straight from flops; VALID drops
// for at least one idle cycle between grants so the mux output can settle.
module mux8_share_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       C,
    input  logic       R,
    input  logic [7:0] REQ,
    input  logic       DONE,
    output logic [7:0] GNT,
    output logic       S,
    output logic       T,
    output logic       U,
    output logic       VALID
);

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 8;

    localparam logic [CW-1:0] CNT_SAT   = '1;
    localparam bit            HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] sel_q, sel_d;
    logic          valid_q, valid_d;

    logic          win_found_c;
    logic [IW-1:0] win_idx_c;
    logic [IW-1:0] cand_c;
    logic          release_c;

    // Round-robin pick: first set request at or after ptr (reverse scan so the nearest wins)
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        cand_c      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand_c = ptr_q + IW'(k);
            if (REQ[cand_c]) begin
                win_found_c = 1'b1;
                win_idx_c   = cand_c;
            end
        end
    end

    // Any one of done, dropped request or hold timeout ends the grant
    always_comb begin
        release_c = DONE || !REQ[idx_q] || (HOLD_EN && (cnt_q == HOLD_LAST));
    end

    // State register
    always_ff @(posedge C) begin
        if (R) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found_c) state_d = BUSY;
            BUSY:    if (release_c)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for pointer, index, counter and the registered outputs
    always_comb begin
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                gnt_d   = '0;
                valid_d = 1'b0;
                if (win_found_c) begin
                    idx_d   = win_idx_c;
                    sel_d   = win_idx_c;
                    gnt_d   = N'(1) << win_idx_c;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
                if (release_c) begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = idx_q + IW'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge C) begin
        if (R) begin
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    assign GNT   = gnt_q;
    assign S     = sel_q[0];
    assign T     = sel_q[1];
    assign U     = sel_q[2];
    assign VALID = valid_q;

endmodule

// File: tb/tb_mux8_share_arbiter.sv
// Bench for mux8_share_arbiter: three instances (hold limits 4, unlimited, 1)
// share one stimulus stream and are checked every cycle against a model.
module tb_mux8_share_arbiter;

    logic       clk = 1'b0;
    logic       r;
    logic [7:0] req;
    logic       done;

    logic [2:0][7:0] gnt_o;
    logic [2:0]      s_o, t_o, u_o, valid_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state per instance
    bit m_busy [3];
    int m_ptr  [3];
    int m_idx  [3];
    int m_held [3];
    int m_sel  [3];

    always #5 clk = ~clk;

    mux8_share_arbiter #(.HOLD_MAX(4)) dut_a (
        .C(clk), .R(r), .REQ(req), .DONE(done),
        .GNT(gnt_o[0]), .S(s_o[0]), .T(t_o[0]), .U(u_o[0]), .VALID(valid_o[0]));
    mux8_share_arbiter #(.HOLD_MAX(0)) dut_b (
        .C(clk), .R(r), .REQ(req), .DONE(done),
        .GNT(gnt_o[1]), .S(s_o[1]), .T(t_o[1]), .U(u_o[1]), .VALID(valid_o[1]));
    mux8_share_arbiter #(.HOLD_MAX(1)) dut_c (
        .C(clk), .R(r), .REQ(req), .DONE(done),
        .GNT(gnt_o[2]), .S(s_o[2]), .T(t_o[2]), .U(u_o[2]), .VALID(valid_o[2]));

    function automatic int hmax(input int d);
        case (d)
            0:       return 4;
            1:       return 0;
            default: return 1;
        endcase
    endfunction

    task automatic check(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %h expected %h at %0t", tag, d, obs, exp, $time);
        end
    endtask

    // Reference behaviour: grant the nearest requester from the pointer, hold until
    // done, request drop or the hold budget is spent, then one idle cycle.
    task automatic model_update();
        for (int d = 0; d < 3; d++) begin
            if (r) begin
                m_busy[d] = 0; m_ptr[d] = 0; m_idx[d] = 0; m_held[d] = 0; m_sel[d] = 0;
            end else if (!m_busy[d]) begin
                if (req != 8'h00) begin
                    bit found;
                    found = 0;
                    for (int k = 0; k < 8; k++) begin
                        int j;
                        j = (m_ptr[d] + k) % 8;
                        if (!found && req[j]) begin
                            found = 1;
                            m_idx[d] = j;
                        end
                    end
                    m_busy[d] = 1;
                    m_sel[d]  = m_idx[d];
                    m_held[d] = 0;
                end
            end else begin
                int  h;
                bit  rel;
                h   = hmax(d);
                rel = done || !req[m_idx[d]] || (h != 0 && m_held[d] + 1 >= h);
                if (rel) begin
                    m_busy[d] = 0;
                    m_ptr[d]  = (m_idx[d] + 1) % 8;
                end else begin
                    m_held[d] = m_held[d] + 1;
                end
            end
        end
    endtask

    // One clock: update model at the edge, compare every instance just after it
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        for (int d = 0; d < 3; d++) begin
            logic [7:0] eg;
            eg = m_busy[d] ? 8'(1 << m_idx[d]) : 8'h00;
            check("gnt",   d, gnt_o[d], eg);
            check("sel",   d, {5'b0, u_o[d], t_o[d], s_o[d]}, 8'(m_sel[d]));
            check("valid", d, {7'b0, valid_o[d]}, {7'b0, m_busy[d]});
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int ridx;
        bit hit;
        r = 1'b1; req = 8'h00; done = 1'b0;

        // Reset, then idle with no requests
        steps(2);
        check("rst_gnt", 1, gnt_o[1], 8'h00);
        r = 1'b0;
        steps(10);
        check("idle_sel", 1, {5'b0, u_o[1], t_o[1], s_o[1]}, 8'h00);

        // Single request on input 5, released by done
        req = 8'h20;
        step();
        check("single_gnt", 1, gnt_o[1], 8'h20);
        check("single_sel", 1, {5'b0, u_o[1], t_o[1], s_o[1]}, 8'h05);
        check("single_valid", 1, {7'b0, valid_o[1]}, 8'h01);
        steps(4);
        done = 1'b1;
        step();
        done = 1'b0;
        check("single_rel", 1, {7'b0, valid_o[1]}, 8'h00);

        // Pointer now 6 on the unlimited instance: 0x41 grants 6, then 0
        req = 8'h41;
        step();
        step();
        check("rot_6", 1, gnt_o[1], 8'h40);
        steps(2);
        done = 1'b1;
        step();
        done = 1'b0;
        check("rot_gap", 1, {7'b0, valid_o[1]}, 8'h00);
        step();
        check("rot_0", 1, gnt_o[1], 8'h01);
        req = 8'h81;
        steps(2);
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        check("rot_7", 1, gnt_o[1], 8'h80);
        req = 8'h00;
        steps(2);

        // All requesting: hold-limited instances rotate through every input
        r = 1'b1; step(); r = 1'b0;
        req = 8'hFF;
        steps(45);

        // Collision: request drop, done and timeout land in the same cycle
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (m_busy[0] && m_held[0] == 3) hit = 1;
            else step();
        end
        n_cmp++;
        assert (hit) else begin
            n_fail++;
            $error("FAIL collision_align: observed %0d expected 1", hit);
        end
        ridx = m_idx[0];
        req  = 8'hFF & ~8'(1 << ridx);
        done = 1'b1;
        step();
        done = 1'b0;
        req  = 8'hFF;
        check("coll_gap", 0, {7'b0, valid_o[0]}, 8'h00);
        step();
        check("coll_next", 0, gnt_o[0], 8'(1 << ((ridx + 1) % 8)));

        // Unlimited hold on input 3 past counter saturation, then reset mid-grant
        r = 1'b1; step(); r = 1'b0;
        req = 8'h08;
        steps(300);
        check("long_hold", 1, gnt_o[1], 8'h08);
        r = 1'b1;
        step();
        check("mid_rst_sel", 1, {5'b0, u_o[1], t_o[1], s_o[1]}, 8'h00);
        r = 1'b0;
        req = 8'hFF;
        step();
        check("post_rst", 1, gnt_o[1], 8'h01);
        steps(3);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 3))
                0:       req = 8'h00;
                1:       req = 8'(1 << $urandom_range(0, 7));
                default: req = 8'($urandom);
            endcase
            done = ($urandom_range(0, 7) == 0);
            r    = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
